// File: rtl/bcd_seg_display.sv
// -----------------------------------------------------------------------------
// bcd_seg_display
//
// Four-digit time-multiplexed driver for a common-anode 7-segment display.
// It sits downstream of the binary-to-BCD converter. Whenever rdy is high, it
// latches the packed BCD result. It then scans the digits with a prescaler so
// each digit stays lit for CLK_DIV clock cycles. The last captured value stays
// on the display until the next capture.
//
// Parameters:
//   CLK_DIV   clk cycles each digit stays lit (>= 2)
//
// Ports:
//   clk       system clock, rising-edge
//   rst_n     asynchronous active-low reset
//   rdy       converter result-valid, sampled every cycle
//   bcd_d_in  packed BCD: [3:0]=ones .. [15:12]=thousands
//   seg_n     segments {g,f,e,d,c,b,a}, active-low, registered
//   an_n      digit enables, active-low one-hot, registered; bit i = nibble i
//   bcd_err   high while any latched nibble is > 9, registered
//
// Optional build macro:
//   BCD_LZB_EN  leading-zero blanking on digits 3..1
// -----------------------------------------------------------------------------
module bcd_seg_display #(
   parameter int unsigned CLK_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic [15:0] bcd_d_in,
   output logic [6:0]  seg_n,
   output logic [3:0]  an_n,
   output logic        bcd_err
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   generate
      if (CLK_DIV < 2) begin : g_bad_div
         $error("bcd_seg_display: CLK_DIV must be >= 2");
      end
   endgenerate

   // Digit decoder, active-low {g,f,e,d,c,b,a}. Non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   function automatic logic any_invalid(input logic [15:0] v);
      return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) ||
             (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
   endfunction

   // State
   logic [15:0]   disp_q, disp_d;
   logic          err_d;
   logic [1:0]    idx_q, idx_d;
   logic [PW-1:0] presc_q, presc_d;

   // Output next-state
   logic [3:0]    cur_nib;
   logic          cur_blank;
   logic [6:0]    seg_d;
   logic [3:0]    an_d;

   // Capture and scan next-state
   always_comb begin
      disp_d  = disp_q;
      err_d   = bcd_err;
      idx_d   = idx_q;
      presc_d = presc_q + PW'(1);

      if (rdy) begin
         disp_d = bcd_d_in;
         err_d  = any_invalid(bcd_d_in);
      end

      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
   end

   // The outputs come from the registered state. So a capture or digit advance
   // on one edge shows up on the display at the following edge.
   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      unique case (idx_q)
         2'd0: cur_nib = disp_q[3:0];
         2'd1: cur_nib = disp_q[7:4];
         2'd2: cur_nib = disp_q[11:8];
         2'd3: cur_nib = disp_q[15:12];
         default: cur_nib = 4'h0;
      endcase

`ifdef BCD_LZB_EN
      // A digit is blanked when it and every more-significant digit are zero.
      // Digit 0 always shows its value.
      unique case (idx_q)
         2'd0: cur_blank = 1'b0;
         2'd1: cur_blank = (disp_q[15:4] == 12'h000);
         2'd2: cur_blank = (disp_q[15:8] == 8'h00);
         2'd3: cur_blank = (disp_q[15:12] == 4'h0);
         default: cur_blank = 1'b0;
      endcase
`else
      cur_blank = 1'b0;
`endif

      seg_d = cur_blank ? SEG_BLANK : seg_decode(cur_nib);
      an_d  = ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q  <= 16'h0000;
         bcd_err <= 1'b0;
         idx_q   <= 2'd0;
         presc_q <= '0;
         an_n    <= 4'b1111;
         seg_n   <= SEG_BLANK;
      end else begin
         disp_q  <= disp_d;
         bcd_err <= err_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         an_n    <= an_d;
         seg_n   <= seg_d;
      end
   end

endmodule

// File: tb/tb_bcd_seg_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_display
//
// Directed, table-driven bench for bcd_seg_display with CLK_DIV=4. The bench
// counts rising edges since reset release. From that count it derives which
// digit should be lit: idx advances on every 4th edge, and the output lags by
// one edge. Expected segment patterns are hand-written per vector.
// Define BCD_LZB_EN for both files to check leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_bcd_seg_display;

   localparam int unsigned DIV = 4;

`ifdef BCD_LZB_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   typedef struct packed {
      logic [15:0]     bcd;
      logic            err;
      logic [3:0][6:0] seg;   // seg[i] = expected seg_n while digit i is lit
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic [15:0] bcd_d_in;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        bcd_err;

   int tests;
   int fails;
   int edges;

   vec_t            vecs [11];
   logic [3:0][6:0] prev;

   bcd_seg_display #(.CLK_DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rdy      (rdy),
      .bcd_d_in (bcd_d_in),
      .seg_n    (seg_n),
      .an_n     (an_n),
      .bcd_err  (bcd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @edge %0d: got %h, expected %h", name, edges, got, exp);
      end
   endtask

   // One rising edge, then settle at the falling edge for sampling and driving.
   task automatic cyc();
      @(posedge clk);
      edges++;
      @(negedge clk);
   endtask

   function automatic int cur_pos();
      return ((edges - 1) / int'(DIV)) % 4;
   endfunction

   task automatic check_scan(input string name, input logic [3:0][6:0] s);
      int p;
      p = cur_pos();
      chk({name, " an_n"}, {4'h0, an_n}, {4'h0, ~(4'b0001 << p)});
      chk({name, " seg_n"}, {1'b0, seg_n}, {1'b0, s[p]});
   endtask

   task automatic run_frames(input string name, input logic [3:0][6:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         check_scan(name, s);
      end
   endtask

   // Single-cycle rdy pulse. The input is scrambled right after the pulse, so
   // the latched value must not follow it.
   task automatic capture(input string name, input vec_t v);
      bcd_d_in = v.bcd;
      rdy      = 1'b1;
      cyc();
      rdy      = 1'b0;
      bcd_d_in = ~v.bcd;
      chk({name, " bcd_err"}, {7'h0, bcd_err}, {7'h0, v.err});
      // The capture edge still shows the previous value.
      check_scan({name, " cap-edge"}, prev);
      prev = v.seg;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      edges    = 0;
      rst_n    = 1'b0;
      rdy      = 1'b0;
      bcd_d_in = 16'h0000;

      vecs[0]  = '{bcd: 16'h4095, err: 1'b0, seg: {7'h19, 7'h40, 7'h10, 7'h12}};
      vecs[1]  = '{bcd: 16'h00A0, err: 1'b1, seg: {LZ,    LZ,    7'h3F, 7'h40}};
      vecs[2]  = '{bcd: 16'h0001, err: 1'b0, seg: {LZ,    LZ,    LZ,    7'h79}};
      vecs[3]  = '{bcd: 16'h0007, err: 1'b0, seg: {LZ,    LZ,    LZ,    7'h78}};
      vecs[4]  = '{bcd: 16'h0000, err: 1'b0, seg: {LZ,    LZ,    LZ,    7'h40}};
      vecs[5]  = '{bcd: 16'h0070, err: 1'b0, seg: {LZ,    LZ,    7'h78, 7'h40}};
      vecs[6]  = '{bcd: 16'h9876, err: 1'b0, seg: {7'h10, 7'h00, 7'h78, 7'h02}};
      vecs[7]  = '{bcd: 16'hF000, err: 1'b1, seg: {7'h3F, 7'h40, 7'h40, 7'h40}};
      vecs[8]  = '{bcd: 16'h0809, err: 1'b0, seg: {LZ,    7'h00, 7'h40, 7'h10}};
      vecs[9]  = '{bcd: 16'hB3C5, err: 1'b1, seg: {7'h3F, 7'h30, 7'h3F, 7'h12}};
      vecs[10] = '{bcd: 16'h1234, err: 1'b0, seg: {7'h79, 7'h24, 7'h30, 7'h19}};

      // Reset state, held for 3 cycles
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset an_n", {4'h0, an_n}, 8'h0F);
         chk("reset seg_n", {1'b0, seg_n}, 8'h7F);
         chk("reset bcd_err", {7'h0, bcd_err}, 8'h00);
      end
      rst_n = 1'b1;
      edges = 0;
      prev  = {LZ, LZ, LZ, 7'h40};

      // Scan order E, D, B, 7, E with 4-cycle dwell on the reset value
      run_frames("post-reset", prev, 20);

      // Table of captures at assorted scan phases
      for (int i = 0; i < 11; i++) begin
         capture($sformatf("vec%0d", i), vecs[i]);
         run_frames($sformatf("vec%0d", i), vecs[i].seg, 16 + i);
      end

      // Capture on the same edge as a digit advance: the next output uses
      // both the new idx and the new value.
      while ((edges % int'(DIV)) != int'(DIV) - 1) cyc();
      capture("sim-adv", vecs[6]);
      run_frames("sim-adv", vecs[6].seg, 8);

      // The display holds 4095 for three frames while rdy=0 and the input
      // changes underneath it.
      capture("hold", vecs[0]);
      bcd_d_in = 16'h1234;
      run_frames("hold", vecs[0].seg, 48);

      // Asynchronous reset mid-frame while digit 2 is lit
      for (int k = 0; k < 16 && cur_pos() != 2; k++) cyc();
      chk("pre-async an_n", {4'h0, an_n}, 8'h0B);
      #2 rst_n = 1'b0;
      #1;
      chk("async an_n", {4'h0, an_n}, 8'h0F);
      chk("async seg_n", {1'b0, seg_n}, 8'h7F);
      chk("async bcd_err", {7'h0, bcd_err}, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      prev  = {LZ, LZ, LZ, 7'h40};
      run_frames("after-async", prev, 16);

      // An error flag set by one capture is cleared by the next valid one.
      capture("err-set", vecs[1]);
      run_frames("err-set", vecs[1].seg, 5);
      capture("err-clr", vecs[2]);
      run_frames("err-clr", vecs[2].seg, 16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
